// File: rtl/window_scan_ctrl.sv
// Raster-scan window fetch controller: walks every output pixel, issues KSIZE x KSIZE
// edge-clamped reads at one per cycle, and hands each result to the plotter via ready/valid.
module window_scan_ctrl #(
  parameter int unsigned IMG_W  = 160,
  parameter int unsigned IMG_H  = 120,
  parameter int unsigned KSIZE  = 3,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned X_W    = 8,
  parameter int unsigned Y_W    = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [2:0]               mode_in,
  output logic [2:0]               mode,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [X_W-1:0]           rd_x,
  output logic [Y_W-1:0]           rd_y,
  output logic [KSIZE*KSIZE-1:0]   tap_ld,
  output logic                     plot,
  input  logic                     plot_ready,
  output logic [X_W-1:0]           out_x,
  output logic [Y_W-1:0]           out_y
);

  localparam int unsigned NTAP = KSIZE * KSIZE;
  localparam int unsigned R    = (KSIZE - 1) / 2;
  localparam int unsigned K_W  = $clog2(NTAP);
  localparam int unsigned C_W  = $clog2(KSIZE);
  localparam int unsigned L_W  = $clog2(RD_LAT + 1);
  localparam int unsigned XS_W = X_W + 1;
  localparam int unsigned YS_W = Y_W + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DRAIN  = 3'd2,
    S_SETTLE = 3'd3,
    S_PLOT   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [C_W-1:0]   col_q, col_d;
  logic [C_W-1:0]   row_q, row_d;
  logic [L_W-1:0]   lat_q, lat_d;
  logic [2:0]       mode_q, mode_d;
  logic             rd_en_q, rd_en_d;
  logic [X_W-1:0]   rd_x_q, rd_x_d;
  logic [Y_W-1:0]   rd_y_q, rd_y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             plot_q, plot_d;
  logic [X_W-1:0]   out_x_q, out_x_d;
  logic [Y_W-1:0]   out_y_q, out_y_d;
  logic [NTAP-1:0]  tap_hot_d;
  logic [NTAP-1:0]  ld_pipe_q [RD_LAT];
  logic             last_pix;

  // Replicate edge pixels: offset is applied one bit wider and signed, then pinned to the frame.
  function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] base, input logic [C_W-1:0] off);
    logic signed [XS_W-1:0] s;
    s = $signed({1'b0, base}) + $signed(XS_W'(off)) - $signed(XS_W'(R));
    if (s[XS_W-1])                            return '0;
    else if (s > $signed(XS_W'(IMG_W - 1)))   return X_W'(IMG_W - 1);
    else                                      return X_W'(s);
  endfunction

  function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] base, input logic [C_W-1:0] off);
    logic signed [YS_W-1:0] s;
    s = $signed({1'b0, base}) + $signed(YS_W'(off)) - $signed(YS_W'(R));
    if (s[YS_W-1])                            return '0;
    else if (s > $signed(YS_W'(IMG_H - 1)))   return Y_W'(IMG_H - 1);
    else                                      return Y_W'(s);
  endfunction

  assign last_pix = (x_q == X_W'(IMG_W - 1)) && (y_q == Y_W'(IMG_H - 1));

  // Next-state, counters and pixel walk.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    col_d   = col_q;
    row_d   = row_q;
    lat_d   = lat_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          mode_d  = mode_in;
          x_d     = '0;
          y_d     = '0;
          k_d     = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_FETCH: begin
        if (k_q == K_W'(NTAP - 1)) begin
          state_d = S_DRAIN;
          lat_d   = '0;
        end else begin
          k_d = k_q + K_W'(1);
          if (col_q == C_W'(KSIZE - 1)) begin
            col_d = '0;
            row_d = row_q + C_W'(1);
          end else begin
            col_d = col_q + C_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (lat_q == L_W'(RD_LAT - 1)) state_d = S_SETTLE;
        else                           lat_d   = lat_q + L_W'(1);
      end
      S_SETTLE: state_d = S_PLOT;
      S_PLOT: begin
        if (plot_ready) begin
          if (last_pix) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            k_d     = '0;
            col_d   = '0;
            row_d   = '0;
            if (x_q == X_W'(IMG_W - 1)) begin
              x_d = '0;
              y_d = y_q + Y_W'(1);
            end else begin
              x_d = x_q + X_W'(1);
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    rd_en_d   = (state_d == S_FETCH);
    rd_x_d    = '0;
    rd_y_d    = '0;
    if (rd_en_d) begin
      rd_x_d = clamp_x(x_d, col_d);
      rd_y_d = clamp_y(y_d, row_d);
    end
    busy_d    = (state_d == S_FETCH) || (state_d == S_DRAIN) ||
                (state_d == S_SETTLE) || (state_d == S_PLOT);
    done_d    = (state_d == S_DONE);
    plot_d    = (state_d == S_PLOT);
    out_x_d   = (state_d == S_IDLE) ? '0 : x_d;
    out_y_d   = (state_d == S_IDLE) ? '0 : y_d;
    tap_hot_d = rd_en_q ? (NTAP'(1) << k_q) : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      lat_q   <= '0;
      mode_q  <= '0;
      rd_en_q <= 1'b0;
      rd_x_q  <= '0;
      rd_y_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      plot_q  <= 1'b0;
      out_x_q <= '0;
      out_y_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) ld_pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      col_q   <= col_d;
      row_q   <= row_d;
      lat_q   <= lat_d;
      mode_q  <= mode_d;
      rd_en_q <= rd_en_d;
      rd_x_q  <= rd_x_d;
      rd_y_q  <= rd_y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      plot_q  <= plot_d;
      out_x_q <= out_x_d;
      out_y_q <= out_y_d;
      // Tap strobe delay line matches the memory read latency.
      ld_pipe_q[0] <= tap_hot_d;
      for (int unsigned i = 1; i < RD_LAT; i++) ld_pipe_q[i] <= ld_pipe_q[i-1];
    end
  end

  assign mode   = mode_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign rd_en  = rd_en_q;
  assign rd_x   = rd_x_q;
  assign rd_y   = rd_y_q;
  assign tap_ld = ld_pipe_q[RD_LAT-1];
  assign plot   = plot_q;
  assign out_x  = out_x_q;
  assign out_y  = out_y_q;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl: a 4x3 / 3x3 / latency-1 instance and a
// 2x2 / 5x5 / latency-3 instance, checked against hand-computed timelines.
module tb_window_scan_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, start_a, start_b, plot_ready;
  logic [2:0] mode_in;

  logic [2:0] mode_a, mode_b;
  logic       busy_a, busy_b, done_a, done_b, rd_en_a, rd_en_b, plot_a, plot_b;
  logic [7:0] rd_x_a, out_x_a;
  logic [6:0] rd_y_a, out_y_a;
  logic [8:0] tap_ld_a;
  logic [1:0] rd_x_b, rd_y_b, out_x_b, out_y_b;
  logic [24:0] tap_ld_b;

  window_scan_ctrl #(.IMG_W(4), .IMG_H(3), .KSIZE(3), .RD_LAT(1), .X_W(8), .Y_W(7)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .mode_in(mode_in), .mode(mode_a),
    .busy(busy_a), .done(done_a), .rd_en(rd_en_a), .rd_x(rd_x_a), .rd_y(rd_y_a),
    .tap_ld(tap_ld_a), .plot(plot_a), .plot_ready(plot_ready), .out_x(out_x_a), .out_y(out_y_a));

  window_scan_ctrl #(.IMG_W(2), .IMG_H(2), .KSIZE(5), .RD_LAT(3), .X_W(2), .Y_W(2)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .mode_in(mode_in), .mode(mode_b),
    .busy(busy_b), .done(done_b), .rd_en(rd_en_b), .rd_x(rd_x_b), .rd_y(rd_y_b),
    .tap_ld(tap_ld_b), .plot(plot_b), .plot_ready(plot_ready), .out_x(out_x_b), .out_y(out_y_b));

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  logic sel;
  logic [31:0] o_mode, o_busy, o_done, o_rd_en, o_rd_x, o_rd_y, o_tap, o_plot, o_out_x, o_out_y;

  always_comb begin
    if (sel) begin
      o_mode = 32'(mode_b);   o_busy = 32'(busy_b);   o_done = 32'(done_b);
      o_rd_en = 32'(rd_en_b); o_rd_x = 32'(rd_x_b);   o_rd_y = 32'(rd_y_b);
      o_tap = 32'(tap_ld_b);  o_plot = 32'(plot_b);   o_out_x = 32'(out_x_b);
      o_out_y = 32'(out_y_b);
    end else begin
      o_mode = 32'(mode_a);   o_busy = 32'(busy_a);   o_done = 32'(done_a);
      o_rd_en = 32'(rd_en_a); o_rd_x = 32'(rd_x_a);   o_rd_y = 32'(rd_y_a);
      o_tap = 32'(tap_ld_a);  o_plot = 32'(plot_a);   o_out_x = 32'(out_x_a);
      o_out_y = 32'(out_y_a);
    end
  end

  logic [31:0] rec_rdx [256];
  logic [31:0] rec_rdy [256];
  logic [31:0] rec_rden [256];
  logic [31:0] rec_tap [256];
  logic [31:0] rec_plot [256];
  logic [31:0] rec_done [256];
  int n_hs, n_rd, n_done, n_p21, n_lt, max_rx, max_ry;

  task automatic check_idle(input string tag);
    check({tag, ".mode"},  o_mode,  32'd0);
    check({tag, ".busy"},  o_busy,  32'd0);
    check({tag, ".done"},  o_done,  32'd0);
    check({tag, ".rd_en"}, o_rd_en, 32'd0);
    check({tag, ".tap"},   o_tap,   32'd0);
    check({tag, ".plot"},  o_plot,  32'd0);
    check({tag, ".out_x"}, o_out_x, 32'd0);
    check({tag, ".out_y"}, o_out_y, 32'd0);
  endtask

  // Runs one frame; mt is the stall-free timeline position, frozen while plot_ready is held low.
  task automatic run_frame(input bit b, input int w, input int h, input int k, input int l,
                           input int sp, input int sl, input int ign, input logic [2:0] m);
    int per, nf, mt, stall_left, p, ph, px, py, cx, cy, guard;
    logic [31:0] etap;
    per = k*k + l + 2;
    nf = w*h*per;
    mt = 0;
    stall_left = sl;
    guard = 0;
    n_hs = 0; n_rd = 0; n_done = 0; n_p21 = 0; n_lt = 0; max_rx = 0; max_ry = 0;
    sel = b;
    mode_in = m;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    start_b = 1'b0;
    while (mt <= nf + 2 && guard < 4000) begin
      guard++;
      p = mt / per; ph = mt % per; px = p % w; py = p / w;
      plot_ready = 1'b1;
      if (mt < nf && p == sp && ph == per - 1 && stall_left > 0) plot_ready = 1'b0;
      if (b) start_b = (mt == ign || mt == nf); else start_a = (mt == ign || mt == nf);
      if (mt == 5) mode_in = ~m;
      if (mt < 256) begin
        rec_rdx[mt] = o_rd_x; rec_rdy[mt] = o_rd_y; rec_rden[mt] = o_rd_en;
        rec_tap[mt] = o_tap;  rec_plot[mt] = o_plot; rec_done[mt] = o_done;
      end
      if (o_plot[0] && plot_ready) n_hs++;
      if (o_rd_en[0]) begin
        n_rd++;
        if (int'(o_rd_x) > max_rx) max_rx = int'(o_rd_x);
        if (int'(o_rd_y) > max_ry) max_ry = int'(o_rd_y);
      end
      if (o_done[0]) n_done++;
      if (o_plot[0] && o_out_x == 32'd2 && o_out_y == 32'd1) n_p21++;
      if (o_tap[k*k-1]) n_lt++;
      if (mt < nf) begin
        check($sformatf("busy@%0d", mt),  o_busy,  32'd1);
        check($sformatf("done@%0d", mt),  o_done,  32'd0);
        check($sformatf("rd_en@%0d", mt), o_rd_en, 32'(ph < k*k));
        if (ph < k*k) begin
          cx = px + ph % k - (k - 1) / 2;
          cy = py + ph / k - (k - 1) / 2;
          if (cx < 0) cx = 0;
          if (cx > w - 1) cx = w - 1;
          if (cy < 0) cy = 0;
          if (cy > h - 1) cy = h - 1;
          check($sformatf("rd_x@%0d", mt), o_rd_x, 32'(cx));
          check($sformatf("rd_y@%0d", mt), o_rd_y, 32'(cy));
        end
        etap = (ph >= l && ph < l + k*k) ? (32'd1 << (ph - l)) : 32'd0;
        check($sformatf("tap_ld@%0d", mt), o_tap, etap);
        check($sformatf("plot@%0d", mt), o_plot, 32'(ph == per - 1));
        check($sformatf("out_x@%0d", mt), o_out_x, 32'(px));
        check($sformatf("out_y@%0d", mt), o_out_y, 32'(py));
        check($sformatf("mode@%0d", mt), o_mode, 32'(m));
      end else if (mt == nf) begin
        check("end.busy", o_busy, 32'd0);
        check("end.done", o_done, 32'd1);
        check("end.rd_en", o_rd_en, 32'd0);
        check("end.tap", o_tap, 32'd0);
        check("end.plot", o_plot, 32'd0);
        check("end.out_x", o_out_x, 32'(w - 1));
        check("end.out_y", o_out_y, 32'(h - 1));
        check("end.mode", o_mode, 32'(m));
      end else begin
        check($sformatf("post.busy@%0d", mt), o_busy, 32'd0);
        check($sformatf("post.done@%0d", mt), o_done, 32'd0);
        check($sformatf("post.rd_en@%0d", mt), o_rd_en, 32'd0);
        check($sformatf("post.tap@%0d", mt), o_tap, 32'd0);
        check($sformatf("post.out_x@%0d", mt), o_out_x, 32'd0);
      end
      if (plot_ready == 1'b0) stall_left--;
      else mt++;
      @(negedge clock);
    end
    check("frame.guard", 32'(guard < 4000), 32'd1);
    start_a = 1'b0;
    start_b = 1'b0;
    plot_ready = 1'b1;
  endtask

  int fx [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
  int fy [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
  int ft [9] = '{'h001, 'h002, 'h004, 'h008, 'h010, 'h020, 'h040, 'h080, 'h100};

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; plot_ready = 1'b1; mode_in = 3'd0; sel = 1'b0;
    repeat (2) @(negedge clock);
    check_idle("reset_a");
    sel = 1'b1; #1;
    check_idle("reset_b");
    sel = 1'b0; #1;
    reset = 1'b0;
    @(negedge clock);

    // Full 4x3 frame, plotter always ready.
    run_frame(1'b0, 4, 3, 3, 1, -1, 0, -1, 3'd5);
    check("first.tap_ld0", rec_tap[0], 32'd0);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("first.rdx%0d", i), rec_rdx[i], 32'(fx[i]));
      check($sformatf("first.rdy%0d", i), rec_rdy[i], 32'(fy[i]));
      check($sformatf("first.tap%0d", i), rec_tap[i+1], 32'(ft[i]));
    end
    check("first.settle", rec_plot[10], 32'd0);
    check("first.plot11", rec_plot[11], 32'd1);
    check("corner.tap0x", rec_rdx[132], 32'd2);
    check("corner.tap0y", rec_rdy[132], 32'd1);
    check("corner.tap8x", rec_rdx[140], 32'd3);
    check("corner.tap8y", rec_rdy[140], 32'd2);
    check("frameA.last_plot", rec_plot[143], 32'd1);
    check("frameA.done144", rec_done[144], 32'd1);
    check("frameA.handshakes", 32'(n_hs), 32'd12);
    check("frameA.done_cnt", 32'(n_done), 32'd1);
    check("frameA.reads", 32'(n_rd), 32'd108);

    // Reset mid-FETCH while tap 4 is on the bus.
    sel = 1'b0; mode_in = 3'd6; start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    repeat (4) @(negedge clock);
    check("midrst.rd_en", o_rd_en, 32'd1);
    check("midrst.tap", o_tap, 32'h008);
    reset = 1'b1;
    @(negedge clock);
    check_idle("midrst");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("midrst.tap+%0d", i), o_tap, 32'd0);
      check($sformatf("midrst.busy+%0d", i), o_busy, 32'd0);
    end

    // Stall 5 cycles at pixel (2,1); stray start and mode_in change mid-frame.
    run_frame(1'b0, 4, 3, 3, 1, 6, 5, 20, 3'd2);
    check("stall.plot21_cycles", 32'(n_p21), 32'd6);
    check("stall.handshakes", 32'(n_hs), 32'd12);
    check("stall.done_cnt", 32'(n_done), 32'd1);

    // 5x5 kernel, latency 3, 2x2 frame.
    run_frame(1'b1, 2, 2, 5, 3, -1, 0, -1, 3'd7);
    check("k5.reads", 32'(n_rd), 32'd100);
    check("k5.last_tap_cnt", 32'(n_lt), 32'd4);
    check("k5.rden24", rec_rden[24], 32'd1);
    check("k5.rden25", rec_rden[25], 32'd0);
    check("k5.tap24", rec_tap[27], 32'h0100_0000);
    check("k5.plot29", rec_plot[29], 32'd1);
    check("k5.plot59", rec_plot[59], 32'd1);
    check("k5.max_rx", 32'(max_rx), 32'd1);
    check("k5.max_ry", 32'(max_ry), 32'd1);
    check("k5.done120", rec_done[120], 32'd1);
    check("k5.done_cnt", 32'(n_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/window_scan_ctrl.md
# window_scan_ctrl

Parametrised raster-scan controller for the neighbourhood filter display path. It walks every output pixel of an IMG_W x IMG_H frame and fetches a KSIZE x KSIZE window for each one. Fetches are pipelined at one read per cycle against a memory of fixed read latency, and image borders are handled by edge replication. Each filtered pixel is presented to the VGA plotter with a ready/valid handshake. It supersedes the fixed 3x3, wait-state-per-tap control path: it adds kernel-size and latency generics, border clamping, start/done framing and plot backpressure.

## Interface
- IMG_W, 160: frame width in pixels
- IMG_H, 120: frame height in pixels
- KSIZE, 3: window side; odd, 3..7; R = (KSIZE-1)/2
- RD_LAT, 1: memory read latency in cycles, >= 1
- X_W, 8: x coordinate width, >= clog2(IMG_W)
- Y_W, 7: y coordinate width, >= clog2(IMG_H)

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset (fixed)
- start  in  1  begin frame; sampled only in IDLE
- mode_in  in  3  filter mode select
- mode  out  3  mode_in latched at accepted start, constant for the frame
- busy  out  1  high in FETCH, DRAIN, SETTLE, PLOT
- done  out  1  one-cycle pulse at frame end
- rd_en  out  1  memory read strobe
- rd_x  out  X_W  read column, already clamped
- rd_y  out  Y_W  read row, already clamped
- tap_ld  out  KSIZE*KSIZE  one-hot load strobe for the window register; bit k loads tap k
- plot  out  1  output pixel valid
- plot_ready  in  1  plotter accepts pixel
- out_x  out  X_W  current output column
- out_y  out  Y_W  current output row

## Operation
- States: IDLE, FETCH, DRAIN, SETTLE, PLOT, DONE.
- IDLE transitions:
  - On start=1: go to FETCH, latch mode, set x=y=0.
  - Otherwise: remain in IDLE.
- FETCH lasts exactly KSIZE*KSIZE cycles, with rd_en=1 on each. Tap index k runs 0..KSIZE^2-1 in row-major order:
  - dy = k/KSIZE - R, dx = k%KSIZE - R.
  - rd_x = clamp(x+dx, 0, IMG_W-1); rd_y = clamp(y+dy, 0, IMG_H-1).
  - Clamping uses signed arithmetic one bit wider than X_W/Y_W; no wrap-around is permitted.
- tap_ld[k] = 1 exactly RD_LAT cycles after the rd_en cycle carrying tap k. tap_ld is never multi-hot and is 0 otherwise.
- DRAIN lasts RD_LAT cycles, rd_en=0, and covers the final tap_ld.
- SETTLE lasts 1 cycle and gives filter datapath settle time.
- PLOT: plot=1 with out_x=x, out_y=y, held stable until plot_ready=1. The handshake completes on the cycle plot and plot_ready are both 1.
- After the handshake:
  - Not the last pixel: go to FETCH. x advances (x=IMG_W-1 wraps to 0 and y increments).
  - x=IMG_W-1 and y=IMG_H-1: go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- start while busy or in DONE is ignored. mode_in changes mid-frame have no effect.
- out_x and out_y equal the current pixel coordinate in every non-IDLE state and are 0 in IDLE.

## Timing
- Reset: the cycle after reset is sampled high, the FSM is in IDLE and all outputs are 0 (mode=0, x=y=0). This applies from any state, including mid-FETCH. The tap_ld pipeline is also cleared, so no stale strobes follow reset.
- First rd_en occurs in the cycle after start is sampled.
- Per-pixel period with plot_ready held 1 is KSIZE^2 + RD_LAT + 2 cycles.
- Frame length with plot_ready held 1 is IMG_W*IMG_H*(KSIZE^2+RD_LAT+2) cycles from the first FETCH to the last PLOT; done follows one cycle later.
- Each cycle plot_ready is 0 stretches PLOT by one cycle. No rd_en or tap_ld occurs during stall cycles.
- A frame of 1x1 is legal: every tap is clamped to (0,0).

## Test plan
- Reset, then start, with IMG_W=4, IMG_H=3, KSIZE=3, RD_LAT=1 -> first pixel reads (0,0),(0,0),(1,0),(0,0),(0,0),(1,0),(0,1),(0,1),(1,1). tap_ld goes 0x001..0x100, each one cycle behind its rd_en. plot is seen at (0,0) 11 cycles after the first rd_en.
- Same configuration, plot_ready tied 1 -> 12 plots in raster order (0,0)..(3,2), each 12 cycles apart; done pulses once, 144 cycles after the first rd_en.
- Hold plot_ready low for 5 cycles at pixel (2,1) -> plot stays high for 6 cycles with out_x=2, out_y=1 stable; no rd_en or tap_ld during the stall.
- Corner pixel (3,2) -> tap 8 reads (3,2) and tap 0 reads (2,1); no out-of-range address is ever driven.
- Assert reset for 1 cycle mid-FETCH at tap 4 -> next cycle is IDLE with all outputs 0 and no further tap_ld. A start pulse while busy in a subsequent frame is ignored.
- KSIZE=5, RD_LAT=3, 2x2 frame -> 25 rd_en per pixel, tap_ld[24] three cycles after the last rd_en, per-pixel period 30 cycles, and rd coordinates clamped to 0..1.
